fifo_mc_serv: RTL
=================

Name: fifo_mc_serv

Overview:
- Parametrised successor to the single-queue FIFO: NUM_CH independent FIFO channels in one block.
- Each channel has valid/ready handshakes on both sides and a per-channel synchronous flush.
- Each channel reports an exact fill count (0..DEPTH inclusive) and an almost-full flag at a fixed threshold.
- Sits between producers and consumers in serv debug/bus paths where several streams need buffering with backpressure.

Parameters:
- NUM_CH, 2, number of independent channels (>=1)
- DATA_WIDTH, 32, payload width per channel
- DEPTH, 8, entries per channel (>=2; need not be a power of two)
- FALL_THROUGH, 0, 1 = an empty channel presents the incoming push on its output in the same cycle
- AF_THRESH, DEPTH-1, almost_full_o asserts when usage >= AF_THRESH (legal 1..DEPTH)
- CNT_W, $clog2(DEPTH+1), derived width of the usage count; do not override

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- testmode_i  in  1  clock-gate bypass; no functional effect
- flush_i  in  NUM_CH  per-channel synchronous flush
- in_valid_i  in  NUM_CH  push request per channel
- in_ready_o  out  NUM_CH  channel can accept data
- in_data_i  in  NUM_CH*DATA_WIDTH  push data; channel c occupies [c*DATA_WIDTH +: DATA_WIDTH]
- out_valid_o  out  NUM_CH  head data available
- out_ready_i  in  NUM_CH  consumer pops the head
- out_data_o  out  NUM_CH*DATA_WIDTH  head data, same packing as in_data_i
- usage_o  out  NUM_CH*CNT_W  fill count per channel, 0..DEPTH
- almost_full_o  out  NUM_CH  usage >= AF_THRESH

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - All pointers and counts clear.
  - in_ready_o = all 1s; out_valid_o = 0; usage_o = 0; almost_full_o = 0.
  - Storage is not reset.
  - out_data_o is don't-care while out_valid_o=0.
- Channels are fully independent; nothing is shared between them except the clock and reset.
- Per channel c:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (usage != DEPTH) & ~flush. in_ready must not depend combinationally on out_ready.
  - out_valid = (usage != 0) | (FALL_THROUGH & in_valid & ~flush), and is 0 during flush.
  - out_data = mem[rd_ptr] when usage != 0; otherwise (FALL_THROUGH only) in_data.
- Pointer update:
  - Write pointer advances on push, read pointer on pop.
  - Each pointer wraps from DEPTH-1 to 0 (explicit compare, not modulo 2^n).
- Usage update:
  - push only: +1.
  - pop only: -1.
  - push & pop together: unchanged; both pointers advance.
- Fall-through bypass (FALL_THROUGH=1, usage==0, push & pop): data passes straight through; pointers, usage and memory are unchanged.
- Latency:
  - FALL_THROUGH=0: data pushed in cycle N is visible on out_data no earlier than cycle N+1.
  - FALL_THROUGH=1: visible in cycle N when the channel is empty.
- Full: in_ready=0, so no write occurs. A pop in the same cycle frees the slot, but the slot is usable only in the next cycle.
- Empty: out_valid=0 (FALL_THROUGH=0), so no pop occurs.
- Flush:
  - Has priority over push and pop in the same cycle.
  - Next cycle: pointers = 0, usage = 0.
  - Other channels are unaffected.
- almost_full registered-consistent: derived combinationally from the registered usage.
- Reset asserted mid-transfer: the channel returns to empty immediately; in-flight data is lost.
- Memory write is enabled only on push; gating the write under testmode_i is allowed.

Optional Feature:
- Macro: FIFO_MC_HIGH_WATER_EN.
- When defined:
  - Adds output port hwm_o (NUM_CH*CNT_W): per-channel maximum usage since reset or last flush.
  - Updated each cycle to max(hwm, usage_next).
  - Cleared to 0 by reset and by that channel's flush_i.
- When undefined: port and registers are absent; all other behaviour is identical.

Test Plan:
- DEPTH=8, FT=0, ch0: push 8 words 0x10..0x17 with out_ready=0 -> in_ready[0]=0 after the 8th, usage=8, almost_full asserted from usage=7; ch1 usage stays 0.
- Then out_ready=1 for 8 cycles -> out_data sequence 0x10..0x17 in order, usage back to 0, out_valid=0.
- DEPTH=5: 20 streaming push/pop cycles at usage=3 -> usage stays 3, data in order across the pointer wrap at 4->0.
- FT=1, empty ch1, push 0xAB with out_ready=1 -> out_valid=1 and out_data=0xAB in the same cycle, usage stays 0.
- ch0 holds 4 entries, flush_i[0]=1 together with in_valid=1 -> in_ready[0]=0, next cycle usage=0; ch1's 2 entries untouched.
- FIFO_MC_HIGH_WATER_EN: fill ch0 to 6, drain to 1 -> hwm=6; flush -> hwm=0. Assert rst_ni mid-fill -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/fifo_mc_serv.sv
// -----------------------------------------------------------------------------
// fifo_mc_serv - NUM_CH independent FIFO channels in one block.
//
// Each channel has valid/ready handshakes on both sides, a synchronous flush,
// an exact fill count (0..DEPTH) and an almost-full flag (usage >= AF_THRESH).
// DEPTH need not be a power of two; pointers wrap by explicit compare.
// With FALL_THROUGH=1 an empty channel presents the incoming word on its
// output in the same cycle; a simultaneous pop then bypasses storage entirely.
//
// Optional feature (macro FIFO_MC_HIGH_WATER_EN): adds hwm_o, the per-channel
// maximum usage since reset or that channel's last flush.
//
// Ports (channel c uses bit c, or slice [c*W +: W] for W-wide buses):
//   clk_i          clock
//   rst_ni         asynchronous active-low reset (pointers/counts only)
//   testmode_i     clock-gate bypass, no functional effect
//   flush_i        per-channel synchronous flush, wins over push/pop
//   in_valid_i     push request
//   in_ready_o     channel can accept a word (never depends on out_ready_i)
//   in_data_i      push data, NUM_CH*DATA_WIDTH
//   out_valid_o    head word available
//   out_ready_i    consumer pops the head
//   out_data_o     head data, NUM_CH*DATA_WIDTH
//   usage_o        fill count, NUM_CH*CNT_W
//   hwm_o          high-water mark, NUM_CH*CNT_W (FIFO_MC_HIGH_WATER_EN only)
//   almost_full_o  usage >= AF_THRESH
// -----------------------------------------------------------------------------
module fifo_mc_serv #(
  parameter int NUM_CH       = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 8,
  parameter int FALL_THROUGH = 0,
  parameter int AF_THRESH    = DEPTH - 1,
  parameter int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         testmode_i,
  input  logic [NUM_CH-1:0]            flush_i,
  input  logic [NUM_CH-1:0]            in_valid_i,
  output logic [NUM_CH-1:0]            in_ready_o,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data_i,
  output logic [NUM_CH-1:0]            out_valid_o,
  input  logic [NUM_CH-1:0]            out_ready_i,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_data_o,
  output logic [NUM_CH*CNT_W-1:0]      usage_o,
`ifdef FIFO_MC_HIGH_WATER_EN
  output logic [NUM_CH*CNT_W-1:0]      hwm_o,
`endif
  output logic [NUM_CH-1:0]            almost_full_o
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic             FT_EN    = (FALL_THROUGH != 0);

  // Storage is written only on push; testmode_i needs no gating here.
  logic unused_testmode;
  assign unused_testmode = testmode_i;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      usage, usage_nxt;
    logic                  empty, full, push, pop, bypass, store;
    logic [DATA_WIDTH-1:0] din;

    assign din   = in_data_i[ch*DATA_WIDTH +: DATA_WIDTH];
    assign empty = (usage == '0);
    assign full  = (usage == DEPTH_C);

    assign in_ready_o[ch]  = ~full & ~flush_i[ch];
    assign out_valid_o[ch] = (~empty | (FT_EN & in_valid_i[ch])) & ~flush_i[ch];

    assign push   = in_valid_i[ch] & in_ready_o[ch];
    assign pop    = out_valid_o[ch] & out_ready_i[ch];
    // Empty fall-through with a same-cycle pop: the word never touches storage.
    assign bypass = FT_EN & empty & push & pop;
    assign store  = push & ~bypass;

    assign out_data_o[ch*DATA_WIDTH +: DATA_WIDTH] = (FT_EN && empty) ? din : mem[rd_ptr];
    assign usage_o[ch*CNT_W +: CNT_W]              = usage;
    assign almost_full_o[ch]                       = (usage >= AF_C);

    always_comb begin
      usage_nxt = usage;
      if (flush_i[ch]) begin
        usage_nxt = '0;
      end else if (!bypass) begin
        case ({push, pop})
          2'b10:   usage_nxt = usage + CNT_W'(1);
          2'b01:   usage_nxt = usage - CNT_W'(1);
          default: usage_nxt = usage;
        endcase
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        usage  <= '0;
      end else begin
        usage <= usage_nxt;
        if (flush_i[ch]) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
        end else begin
          if (store) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
          if (pop && !bypass) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (store) mem[wr_ptr] <= din;
    end

`ifdef FIFO_MC_HIGH_WATER_EN
    logic [CNT_W-1:0] hwm;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        hwm <= '0;
      end else if (flush_i[ch]) begin
        hwm <= '0;
      end else if (usage_nxt > hwm) begin
        hwm <= usage_nxt;
      end
    end

    assign hwm_o[ch*CNT_W +: CNT_W] = hwm;
`endif
  end

endmodule
